rtc_multitimer: RTL and testbench

Multi-channel successor to the single count-down timer in the RTC core: NTIMERS independent count-down timers sharing one programmable fractional-rate sub-second tick generator. Each channel supports one-shot or auto-reload mode, a sticky trip flag and a maskable interrupt. Wishbone-slave register block, instantiated beside the RTC clock/alarm logic. It drives the interrupt controller and provides o_tick/o_pps to neighbouring blocks.

---
 rtl/rtc_pkg.sv | 20 ++
 rtl/rtc_multitimer_if.sv | 24 ++
 rtl/rtc_tickgen.sv | 36 +++
 rtl/rtc_multitimer.sv | 136 +++++++++++++
 tb/tb_rtc_multitimer.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared RTC register map, control bit positions and reset speed
package rtc_pkg;

   localparam logic [3:0]  ADDR_SPEED      = 4'd0;
   localparam logic [3:0]  ADDR_STATUS     = 4'd1;
   localparam logic [3:0]  ADDR_ENABLE     = 4'd2;
   localparam logic [3:0]  ADDR_TIMER_BASE = 4'd8;

   localparam int          RUN_BIT  = 31;
   localparam int          AUTO_BIT = 30;
   localparam int          TRIP_BIT = 29;

   // 2^48 / f_clk for the reference clock the RTC core is normally built with
   localparam logic [31:0] DEFAULT_SPEED = 32'd2814750;

   function automatic logic full_word(input logic [3:0] sel);
      return sel == 4'hF;
   endfunction

endpackage

// File: rtl/rtc_multitimer_if.sv
// rtl/rtc_multitimer_if.sv - Wishbone-style register bus between a master and the multitimer
interface rtc_multitimer_if;

   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic [3:0]  i_wb_addr;
   logic [31:0] i_wb_data;
   logic [3:0]  i_wb_sel;
   logic        o_wb_stall;
   logic        o_wb_ack;
   logic [31:0] o_wb_data;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      input  o_wb_stall, o_wb_ack, o_wb_data
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      output o_wb_stall, o_wb_ack, o_wb_data
   );

endinterface

// File: rtl/rtc_tickgen.sv
// rtl/rtc_tickgen.sv - fractional-rate sub-second tick and pulse-per-second generator
module rtc_tickgen #(
   parameter int LGSUBCK = 8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_speed,
   output logic        o_tick,
   output logic        o_pps
);

   localparam int W = 48 - LGSUBCK;

   logic [W-1:0]       acc;
   logic [W:0]         sum;
   logic [LGSUBCK-1:0] subsec;

   // speed is a fraction of one tick per clock scaled by 2^W; the carry out is the tick
   assign sum = {1'b0, acc} + {{(W-31){1'b0}}, i_speed};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc    <= '0;
         o_tick <= 1'b0;
         subsec <= '0;
      end else begin
         acc    <= sum[W-1:0];
         o_tick <= sum[W];
         if (o_tick)
            subsec <= subsec + LGSUBCK'(1);
      end
   end

   assign o_pps = o_tick && (&subsec);

endmodule

// File: rtl/rtc_multitimer.sv
// rtl/rtc_multitimer.sv - NTIMERS count-down timers on a shared sub-second tick, bus register block
module rtc_multitimer #(
   parameter int          NTIMERS       = 4,
   parameter int          LGSUBCK       = 8,
   parameter int          CW            = 24,
   parameter logic [31:0] DEFAULT_SPEED = rtc_pkg::DEFAULT_SPEED
) (
   input  logic          i_clk,
   input  logic          i_reset,
   rtc_multitimer_if.slave wb,
   output logic          o_int,
   output logic          o_tick,
   output logic          o_pps
);

   import rtc_pkg::*;

   logic [31:0]        speed;
   logic [NTIMERS-1:0] status;
   logic [NTIMERS-1:0] enable;
   logic [NTIMERS-1:0] trip;
   logic [NTIMERS-1:0] clr;
   logic               run_q  [NTIMERS];
   logic               auto_q [NTIMERS];
   logic [CW-1:0]      cnt_q  [NTIMERS];
   logic [CW-1:0]      rel_q  [NTIMERS];
   logic [31:0]        rdata;
   logic               wr;
   logic               load;
   logic               unused_bits;

   assign wr          = wb.i_wb_stb && wb.i_wb_we;
   assign load        = &wb.i_wb_sel[2:0];
   assign clr         = (wr && wb.i_wb_addr == ADDR_STATUS) ? wb.i_wb_data[NTIMERS-1:0] : '0;
   assign wb.o_wb_stall = 1'b0;
   assign unused_bits = ^{wb.i_wb_cyc, wb.i_wb_data};

   rtc_tickgen #(
      .LGSUBCK (LGSUBCK)
   ) u_tickgen (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_speed (speed),
      .o_tick  (o_tick),
      .o_pps   (o_pps)
   );

   for (genvar k = 0; k < NTIMERS; k++) begin : g_timer
      localparam logic [3:0] TADDR = ADDR_TIMER_BASE + 4'(k);

      logic          wsel;
      logic          run_w;
      logic          auto_w;
      logic [CW-1:0] cnt_w;
      logic [CW-1:0] rel_w;

      assign wsel   = wr && (wb.i_wb_addr == TADDR);
      assign run_w  = wb.i_wb_sel[3] ? wb.i_wb_data[RUN_BIT]  : run_q[k];
      assign auto_w = wb.i_wb_sel[3] ? wb.i_wb_data[AUTO_BIT] : auto_q[k];
      assign cnt_w  = load ? wb.i_wb_data[CW-1:0] : cnt_q[k];
      assign rel_w  = load ? wb.i_wb_data[CW-1:0] : rel_q[k];

      // a bus write to this channel swallows a coincident tick
      assign trip[k] = !wsel && o_tick && run_q[k] && (cnt_q[k] == CW'(1));

      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            run_q[k]  <= 1'b0;
            auto_q[k] <= 1'b0;
            cnt_q[k]  <= '0;
            rel_q[k]  <= '0;
         end else if (wsel) begin
            run_q[k]  <= run_w && ((cnt_w != '0) || (rel_w != '0));
            auto_q[k] <= auto_w;
            cnt_q[k]  <= cnt_w;
            rel_q[k]  <= rel_w;
         end else if (o_tick && run_q[k] && (cnt_q[k] != '0)) begin
            if (cnt_q[k] != CW'(1)) begin
               cnt_q[k] <= cnt_q[k] - CW'(1);
            end else if (auto_q[k] && (rel_q[k] != '0)) begin
               cnt_q[k] <= rel_q[k];
            end else begin
               cnt_q[k] <= '0;
               run_q[k] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         speed  <= DEFAULT_SPEED;
         status <= '0;
         enable <= '0;
         o_int  <= 1'b0;
      end else begin
         if (wr && wb.i_wb_addr == ADDR_SPEED && full_word(wb.i_wb_sel))
            speed <= wb.i_wb_data;
         if (wr && wb.i_wb_addr == ADDR_ENABLE)
            enable <= wb.i_wb_data[NTIMERS-1:0];
         // set has priority so a trip racing a clear is never lost
         status <= (status & ~clr) | trip;
         o_int  <= |(status & enable);
      end
   end

   always_comb begin
      rdata = '0;
      if (wb.i_wb_addr == ADDR_SPEED)
         rdata = speed;
      else if (wb.i_wb_addr == ADDR_STATUS)
         rdata[NTIMERS-1:0] = status;
      else if (wb.i_wb_addr == ADDR_ENABLE)
         rdata[NTIMERS-1:0] = enable;
      for (int k = 0; k < NTIMERS; k++) begin
         if (wb.i_wb_addr == ADDR_TIMER_BASE + 4'(k)) begin
            rdata[RUN_BIT]  = run_q[k];
            rdata[AUTO_BIT] = auto_q[k];
            rdata[TRIP_BIT] = status[k];
            rdata[CW-1:0]   = cnt_q[k];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wb.o_wb_ack  <= 1'b0;
         wb.o_wb_data <= '0;
      end else begin
         wb.o_wb_ack <= wb.i_wb_stb;
         if (wb.i_wb_stb)
            wb.o_wb_data <= rdata;
      end
   end

endmodule

// File: tb/tb_rtc_multitimer.sv
// tb/tb_rtc_multitimer.sv - randomized scoreboard bench for rtc_multitimer against a tick-count model
module tb_rtc_multitimer;

   localparam int          N   = 4;
   localparam int          LG  = 8;
   localparam int          CW  = 24;
   localparam int          W   = 48 - LG;
   localparam logic [31:0] DEF = 32'd2814750;

   typedef struct {
      logic        chk;
      logic [3:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic i_clk = 1'b0;
   logic i_reset;
   logic o_int, o_tick, o_pps;

   rtc_multitimer_if bus ();

   rtc_multitimer #(
      .NTIMERS       (N),
      .LGSUBCK       (LG),
      .CW            (CW),
      .DEFAULT_SPEED (DEF)
   ) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .wb      (bus),
      .o_int   (o_int),
      .o_tick  (o_tick),
      .o_pps   (o_pps)
   );

   always #5 i_clk = ~i_clk;

   // model: ticks come from the running total of speed added each clock
   logic [63:0]   m_total;
   logic          m_tick;
   int            m_ticks;
   logic [31:0]   m_speed;
   logic [CW-1:0] m_cnt  [N];
   logic [CW-1:0] m_rel  [N];
   logic          m_run  [N];
   logic          m_auto [N];
   logic [N-1:0]  m_stat, m_en;
   logic          m_int;

   logic [63:0]   n_total;
   logic          n_tick;
   logic [CW-1:0] n_cnt  [N];
   logic [CW-1:0] n_rel  [N];
   logic          n_run  [N];
   logic          n_auto [N];
   logic [N-1:0]  n_stat, trips, clr;
   logic          wr;

   exp_t sbq [$];
   exp_t e;
   int   checks   = 0;
   int   failures = 0;
   logic mon_en   = 1'b0;

   function automatic logic [31:0] m_read(input logic [3:0] a);
      logic [31:0] v;
      int ai;
      v  = '0;
      ai = int'(a);
      if (ai == 0) v = m_speed;
      else if (ai == 1) v[N-1:0] = m_stat;
      else if (ai == 2) v[N-1:0] = m_en;
      else if (ai >= 8 && ai < 8 + N) begin
         v[31]     = m_run[ai-8];
         v[30]     = m_auto[ai-8];
         v[29]     = m_stat[ai-8];
         v[CW-1:0] = m_cnt[ai-8];
      end
      return v;
   endfunction

   always_comb begin
      wr      = bus.i_wb_stb && bus.i_wb_we;
      n_total = m_total + {32'd0, m_speed};
      n_tick  = (n_total >> W) != (m_total >> W);
      trips   = '0;
      clr     = (wr && bus.i_wb_addr == 4'd1) ? bus.i_wb_data[N-1:0] : '0;
      for (int k = 0; k < N; k++) begin
         n_cnt[k]  = m_cnt[k];
         n_rel[k]  = m_rel[k];
         n_run[k]  = m_run[k];
         n_auto[k] = m_auto[k];
         if (wr && int'(bus.i_wb_addr) == 8 + k) begin
            if (bus.i_wb_sel[3]) begin
               n_run[k]  = bus.i_wb_data[31];
               n_auto[k] = bus.i_wb_data[30];
            end
            if (bus.i_wb_sel[2:0] == 3'b111) begin
               n_cnt[k] = bus.i_wb_data[CW-1:0];
               n_rel[k] = bus.i_wb_data[CW-1:0];
            end
            if (n_cnt[k] == 0 && n_rel[k] == 0) n_run[k] = 1'b0;
         end else if (m_tick && m_run[k] && m_cnt[k] != 0) begin
            n_cnt[k] = m_cnt[k] - 1;
            if (n_cnt[k] == 0) begin
               trips[k] = 1'b1;
               if (m_auto[k] && m_rel[k] != 0) n_cnt[k] = m_rel[k];
               else n_run[k] = 1'b0;
            end
         end
      end
      n_stat = (m_stat & ~clr) | trips;
   end

   always @(posedge i_clk) begin
      if (i_reset) begin
         m_total <= '0;
         m_tick  <= 1'b0;
         m_ticks <= 0;
         m_speed <= DEF;
         m_stat  <= '0;
         m_en    <= '0;
         m_int   <= 1'b0;
         for (int k = 0; k < N; k++) begin
            m_cnt[k]  <= '0;
            m_rel[k]  <= '0;
            m_run[k]  <= 1'b0;
            m_auto[k] <= 1'b0;
         end
      end else begin
         if (bus.i_wb_stb)
            sbq.push_back('{!bus.i_wb_we, bus.i_wb_addr, m_read(bus.i_wb_addr)});
         m_total <= n_total;
         m_tick  <= n_tick;
         if (m_tick) m_ticks <= m_ticks + 1;
         if (wr && bus.i_wb_addr == 4'd0 && bus.i_wb_sel == 4'hF) m_speed <= bus.i_wb_data;
         if (wr && bus.i_wb_addr == 4'd2) m_en <= bus.i_wb_data[N-1:0];
         m_stat <= n_stat;
         m_int  <= |(m_stat & m_en);
         for (int k = 0; k < N; k++) begin
            m_cnt[k]  <= n_cnt[k];
            m_rel[k]  <= n_rel[k];
            m_run[k]  <= n_run[k];
            m_auto[k] <= n_auto[k];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge i_clk) begin
      if (mon_en) begin
         check("o_int", 32'(o_int), 32'(m_int));
         check("o_tick", 32'(o_tick), 32'(m_tick));
         check("o_pps", 32'(o_pps), 32'(m_tick && (m_ticks % (1 << LG)) == (1 << LG) - 1));
         check("o_wb_stall", 32'(bus.o_wb_stall), 32'd0);
         if (bus.o_wb_ack) begin
            if (sbq.size() == 0) begin
               check("unexpected_ack", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               if (e.chk) check($sformatf("read_addr%0d", e.addr), bus.o_wb_data, e.data);
            end
         end else if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check($sformatf("missing_ack_addr%0d", e.addr), 32'd0, 32'd1);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic access(input logic we, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      bus.i_wb_cyc  = 1'b1;
      bus.i_wb_stb  = 1'b1;
      bus.i_wb_we   = we;
      bus.i_wb_addr = a;
      bus.i_wb_data = d;
      bus.i_wb_sel  = s;
      @(posedge i_clk);
      #1;
      bus.i_wb_cyc  = 1'b0;
      bus.i_wb_stb  = 1'b0;
      bus.i_wb_we   = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a);
      access(1'b0, a, 32'd0, 4'hF);
   endtask

   task automatic wrt(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      access(1'b1, a, d, s);
   endtask

   task automatic wait_tick_cycle();
      int b = 0;
      while (!m_tick) begin
         @(posedge i_clk);
         #1;
         b++;
         if (b > 5000) begin
            $display("FAIL tick_wait_timeout at %0t", $time);
            $fatal(1, "tick wait expired");
         end
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         wait_tick_cycle();
         idle(1);
      end
   endtask

   logic [3:0]  r_a, r_s;
   logic [31:0] r_d;
   int          b;

   initial begin
      i_reset       = 1'b1;
      bus.i_wb_cyc  = 1'b0;
      bus.i_wb_stb  = 1'b0;
      bus.i_wb_we   = 1'b0;
      bus.i_wb_addr = '0;
      bus.i_wb_data = '0;
      bus.i_wb_sel  = '0;
      repeat (2) @(posedge i_clk);
      #1;
      mon_en  = 1'b1;
      idle(1);
      i_reset = 1'b0;

      foreach (r_d[i]) if (i < 16) begin r_a = 4'(i); rd(r_a); end

      wrt(4'd0, 32'h4000_0000, 4'hF);
      wrt(4'd8, 32'h8000_0003, 4'hF);
      wrt(4'd2, 32'h1, 4'hF);
      wait_ticks(3);
      idle(3);
      rd(4'd1);
      rd(4'd8);
      wrt(4'd1, 32'h1, 4'hF);
      idle(3);
      rd(4'd1);

      wrt(4'd9, 32'hC000_0002, 4'hF);
      wrt(4'd2, 32'h3, 4'hF);
      wait_ticks(3);
      rd(4'd1);
      rd(4'd9);
      wrt(4'd1, 32'h2, 4'hF);
      b = 0;
      while (!(m_tick && m_run[1] && m_cnt[1] == 1) && b < 5000) begin
         idle(1);
         b++;
      end
      wrt(4'd1, 32'h2, 4'hF);
      rd(4'd1);
      rd(4'd9);

      wait_tick_cycle();
      wrt(4'd10, 32'h8000_0005, 4'hF);
      rd(4'd10);
      rd(4'd9);
      rd(4'd8);

      wrt(4'd11, 32'h8000_000A, 4'hF);
      idle(100);
      wrt(4'd11, 32'h0000_0000, 4'b1000);
      rd(4'd11);
      wait_ticks(2);
      rd(4'd11);
      wrt(4'd11, 32'h8000_0000, 4'b1000);
      wait_ticks(2);
      rd(4'd11);
      wrt(4'd11, 32'h8000_0020, 4'b0011);
      rd(4'd11);
      wrt(4'd0, 32'h1234_5678, 4'b0011);
      rd(4'd0);

      for (int i = 0; i < 120; i++) begin
         r_a = 4'($urandom_range(0, 15));
         r_d = $urandom();
         r_d[23:0] = 24'($urandom_range(0, 6));
         if (r_a == 4'd0)
            r_d = ($urandom_range(0, 3) == 0) ? 32'h0 : (32'h4000_0000 << $urandom_range(0, 1));
         r_s = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) rd(r_a);
         else wrt(r_a, r_d, r_s);
         idle($urandom_range(0, 300));
      end

      wrt(4'd0, 32'h4000_0000, 4'hF);
      wrt(4'd8, 32'h8000_0007, 4'hF);
      wrt(4'd9, 32'hC000_0003, 4'hF);
      wrt(4'd2, 32'hF, 4'hF);
      wait_ticks(2);
      idle(5);
      bus.i_wb_stb  = 1'b1;
      bus.i_wb_cyc  = 1'b1;
      bus.i_wb_addr = 4'd8;
      i_reset       = 1'b1;
      idle(1);
      bus.i_wb_stb  = 1'b0;
      bus.i_wb_cyc  = 1'b0;
      idle(1);
      i_reset = 1'b0;
      rd(4'd0);
      rd(4'd1);
      rd(4'd2);
      rd(4'd8);
      rd(4'd9);
      idle(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
